// File: rtl/ooo_pkg.sv
// Types and widths shared by the reservation station, reorder buffer and CDB.
package ooo_pkg;

    localparam int unsigned TAG_WIDTH  = 4;
    localparam int unsigned OP_WIDTH   = 6;
    localparam int unsigned DATA_WIDTH = 32;

    typedef struct packed {
        logic                  rdy;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic                 valid;
        logic [OP_WIDTH-1:0]  op;
        logic [TAG_WIDTH-1:0] rob_tag;
        rs_src_t              a;
        rs_src_t              b;
    } rs_entry_t;

    function automatic rs_src_t make_src(input logic                  rdy,
                                         input logic [TAG_WIDTH-1:0]  tag,
                                         input logic [DATA_WIDTH-1:0] val);
        rs_src_t s;
        s.rdy = rdy;
        s.tag = tag;
        s.val = val;
        return s;
    endfunction

endpackage

// File: rtl/rs_operand_capture.sv
// Compares one waiting source operand against the CDB and produces its next {rdy, val}.
module rs_operand_capture
    import ooo_pkg::*;
(
    input  rs_src_t                src_i,
    input  logic                   cdb_valid_i,
    input  logic [TAG_WIDTH-1:0]   cdb_tag_i,
    input  logic [DATA_WIDTH-1:0]  cdb_data_i,
    output rs_src_t                src_o
);

    logic hit;

    always_comb begin
        hit   = cdb_valid_i & ~src_i.rdy & (src_i.tag == cdb_tag_i);
        src_o = src_i;
        if (hit) begin
            src_o.rdy = 1'b1;
            src_o.val = cdb_data_i;
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station feeding one ALU; index 0 holds the oldest entry.
// Optional 0-cycle CDB wakeup-to-issue bypass enabled by defining RS_WAKEUP_BYPASS_EN.
module reservation_station #(
    parameter int RS_DEPTH   = 4,
    parameter int DATA_WIDTH = ooo_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = ooo_pkg::TAG_WIDTH,
    parameter int OP_WIDTH   = ooo_pkg::OP_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [OP_WIDTH-1:0]            disp_op,
    input  logic [TAG_WIDTH-1:0]           disp_rob_tag,
    input  logic                           disp_a_rdy,
    input  logic                           disp_b_rdy,
    input  logic [DATA_WIDTH-1:0]          disp_a_val,
    input  logic [DATA_WIDTH-1:0]          disp_b_val,
    input  logic [TAG_WIDTH-1:0]           disp_a_tag,
    input  logic [TAG_WIDTH-1:0]           disp_b_tag,
    input  logic                           cdb_valid,
    input  logic [TAG_WIDTH-1:0]           cdb_tag,
    input  logic [DATA_WIDTH-1:0]          cdb_data,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [OP_WIDTH-1:0]            issue_op,
    output logic [TAG_WIDTH-1:0]           issue_rob_tag,
    output logic [DATA_WIDTH-1:0]          issue_a,
    output logic [DATA_WIDTH-1:0]          issue_b,
    output logic [$clog2(RS_DEPTH+1)-1:0]  occupancy
);

    import ooo_pkg::*;

    localparam int OCC_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    rs_entry_t           entries_q [RS_DEPTH];
    rs_entry_t           entries_d [RS_DEPTH];
    rs_src_t             woken_a   [RS_DEPTH];
    rs_src_t             woken_b   [RS_DEPTH];
    rs_entry_t           woken     [RS_DEPTH];
    logic [OCC_W-1:0]    occupancy_q, occupancy_d, occ_after_issue;
    logic [RS_DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0]    sel_idx;
    logic                any_ready, issue_fire, disp_fire;
    rs_src_t             disp_a_cap, disp_b_cap;
    rs_entry_t           new_entry;

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
        rs_operand_capture u_cap_a (
            .src_i       (entries_q[i].a),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .src_o       (woken_a[i])
        );
        rs_operand_capture u_cap_b (
            .src_i       (entries_q[i].b),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .src_o       (woken_b[i])
        );

        always_comb begin
            woken[i]   = entries_q[i];
            woken[i].a = woken_a[i];
            woken[i].b = woken_b[i];
        end

`ifdef RS_WAKEUP_BYPASS_EN
        assign ready_vec[i] = entries_q[i].valid & woken_a[i].rdy & woken_b[i].rdy;
`else
        assign ready_vec[i] = entries_q[i].valid & entries_q[i].a.rdy & entries_q[i].b.rdy;
`endif
    end

    // A source that arrives with the CDB broadcast of its producer must not miss it.
    rs_operand_capture u_disp_cap_a (
        .src_i       (make_src(disp_a_rdy, disp_a_tag, disp_a_val)),
        .cdb_valid_i (cdb_valid),
        .cdb_tag_i   (cdb_tag),
        .cdb_data_i  (cdb_data),
        .src_o       (disp_a_cap)
    );
    rs_operand_capture u_disp_cap_b (
        .src_i       (make_src(disp_b_rdy, disp_b_tag, disp_b_val)),
        .cdb_valid_i (cdb_valid),
        .cdb_tag_i   (cdb_tag),
        .cdb_data_i  (cdb_data),
        .src_o       (disp_b_cap)
    );

    always_comb begin
        sel_idx   = '0;
        any_ready = 1'b0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    // Operand values come from the woken view so a bypassed operand carries cdb_data.
    always_comb begin
        issue_valid   = any_ready & ~flush & ~rst;
        issue_op      = '0;
        issue_rob_tag = '0;
        issue_a       = '0;
        issue_b       = '0;
        if (issue_valid) begin
            issue_op      = woken[sel_idx].op;
            issue_rob_tag = woken[sel_idx].rob_tag;
            issue_a       = woken[sel_idx].a.val;
            issue_b       = woken[sel_idx].b.val;
        end
    end

    assign disp_ready = (occupancy_q < OCC_W'(RS_DEPTH));
    assign occupancy  = occupancy_q;
    assign issue_fire = issue_valid & issue_ready;
    assign disp_fire  = disp_valid & disp_ready & ~flush;

    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.op      = disp_op;
        new_entry.rob_tag = disp_rob_tag;
        new_entry.a       = disp_a_cap;
        new_entry.b       = disp_b_cap;
    end

    // Collapse first, then append, so dispatch and issue together keep occupancy unchanged.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            entries_d[i] = woken[i];
        end
        occ_after_issue = occupancy_q;
        if (issue_fire) begin
            for (int i = 0; i < RS_DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    entries_d[i] = woken[i+1];
                end
            end
            entries_d[RS_DEPTH-1] = '0;
            occ_after_issue       = occupancy_q - OCC_W'(1);
        end
        occupancy_d = occ_after_issue;
        if (disp_fire) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (OCC_W'(i) == occ_after_issue) begin
                    entries_d[i] = new_entry;
                end
            end
            occupancy_d = occ_after_issue + OCC_W'(1);
        end
        if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_d[i]       = entries_q[i];
                entries_d[i].valid = 1'b0;
            end
            occupancy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            occupancy_q <= occupancy_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus random traffic
// checked every cycle against an in-order queue model.
module tb_reservation_station;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, disp_valid, disp_ready;
    logic [5:0]  disp_op;
    logic [3:0]  disp_rob_tag, disp_a_tag, disp_b_tag, cdb_tag, issue_rob_tag;
    logic        disp_a_rdy, disp_b_rdy, cdb_valid, issue_valid, issue_ready;
    logic [31:0] disp_a_val, disp_b_val, cdb_data, issue_a, issue_b;
    logic [5:0]  issue_op;
    logic [2:0]  occupancy;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  tag;
        bit          ar, br;
        logic [3:0]  at, bt;
        logic [31:0] av, bv;
    } ment_t;

    ment_t q[$];

    always #5 clk = ~clk;

    reservation_station dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_op       (disp_op),
        .disp_rob_tag  (disp_rob_tag),
        .disp_a_rdy    (disp_a_rdy),
        .disp_b_rdy    (disp_b_rdy),
        .disp_a_val    (disp_a_val),
        .disp_b_val    (disp_b_val),
        .disp_a_tag    (disp_a_tag),
        .disp_b_tag    (disp_b_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_op      (issue_op),
        .issue_rob_tag (issue_rob_tag),
        .issue_a       (issue_a),
        .issue_b       (issue_b),
        .occupancy     (occupancy)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Readiness of a source as seen by select this cycle.
    function automatic bit src_ok(input bit r, input logic [3:0] t);
`ifdef RS_WAKEUP_BYPASS_EN
        return r || (cdb_valid && t == cdb_tag);
`else
        return r;
`endif
    endfunction

    function automatic logic [31:0] src_val(input bit r, input logic [3:0] t,
                                            input logic [31:0] v);
        if (!r && cdb_valid && t == cdb_tag) return cdb_data;
        return v;
    endfunction

    // Check outputs against the model, then advance the model and the clock by one cycle.
    task automatic cycle();
        int    sel = -1;
        bit    accept;
        ment_t n;
        #1;
        if (!rst) begin
            if (!flush) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (sel < 0 && src_ok(q[i].ar, q[i].at) && src_ok(q[i].br, q[i].bt)) sel = i;
                end
            end
            check("occupancy", 64'(occupancy), 64'(q.size()));
            check("disp_ready", 64'(disp_ready), 64'(q.size() < DEPTH));
            check("issue_valid", 64'(issue_valid), 64'(sel >= 0));
            if (sel >= 0) begin
                check("issue_op", 64'(issue_op), 64'(q[sel].op));
                check("issue_rob_tag", 64'(issue_rob_tag), 64'(q[sel].tag));
                check("issue_a", 64'(issue_a), 64'(src_val(q[sel].ar, q[sel].at, q[sel].av)));
                check("issue_b", 64'(issue_b), 64'(src_val(q[sel].br, q[sel].bt, q[sel].bv)));
            end
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            accept = disp_valid && q.size() < DEPTH;
            n.op = disp_op;
            n.tag = disp_rob_tag;
            n.ar = disp_a_rdy || (cdb_valid && disp_a_tag == cdb_tag);
            n.br = disp_b_rdy || (cdb_valid && disp_b_tag == cdb_tag);
            n.at = disp_a_tag;
            n.bt = disp_b_tag;
            n.av = src_val(disp_a_rdy, disp_a_tag, disp_a_val);
            n.bv = src_val(disp_b_rdy, disp_b_tag, disp_b_val);
            for (int i = 0; i < q.size(); i++) begin
                q[i].av = src_val(q[i].ar, q[i].at, q[i].av);
                q[i].bv = src_val(q[i].br, q[i].bt, q[i].bv);
                q[i].ar = q[i].ar || (cdb_valid && q[i].at == cdb_tag);
                q[i].br = q[i].br || (cdb_valid && q[i].bt == cdb_tag);
            end
            if (sel >= 0 && issue_ready) q.delete(sel);
            if (accept) q.push_back(n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic disp(input logic [5:0] op, input logic [3:0] tag,
                        input bit ar, input logic [3:0] at, input logic [31:0] av,
                        input bit br, input logic [3:0] bt, input logic [31:0] bv);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_rob_tag = tag;
        disp_a_rdy   = ar;
        disp_a_tag   = at;
        disp_a_val   = av;
        disp_b_rdy   = br;
        disp_b_tag   = bt;
        disp_b_val   = bv;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
        disp_op = '0; disp_rob_tag = '0; disp_a_rdy = 1'b0; disp_b_rdy = 1'b0;
        disp_a_tag = '0; disp_b_tag = '0; disp_a_val = '0; disp_b_val = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_op", 64'(issue_op), 64'd0);
        check("rst_issue_rob_tag", 64'(issue_rob_tag), 64'd0);
        check("rst_issue_a", 64'(issue_a), 64'd0);
        check("rst_issue_b", 64'(issue_b), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        cycle();

        // Both sources ready: issuable the cycle after dispatch.
        disp(6'h20, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        issue_ready = 1'b1;
        cycle();
        disp_valid = 1'b0;
        #1;
        check("t1_valid", 64'(issue_valid), 64'd1);
        check("t1_a", 64'(issue_a), 64'd5);
        check("t1_b", 64'(issue_b), 64'd7);
        check("t1_tag", 64'(issue_rob_tag), 64'd3);
        check("t1_op", 64'(issue_op), 64'h20);
        cycle();
        #1;
        check("t1_occ_empty", 64'(occupancy), 64'd0);

        // Source A woken by the CDB two cycles after dispatch.
        disp(6'h01, 4'd1, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd2);
        cycle();
        disp_valid = 1'b0;
        cycle();
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h1234;
        #1;
`ifdef RS_WAKEUP_BYPASS_EN
        check("t2_bypass_valid", 64'(issue_valid), 64'd1);
        check("t2_bypass_a", 64'(issue_a), 64'h1234);
`else
        check("t2_cdb_cycle_valid", 64'(issue_valid), 64'd0);
`endif
        cycle();
        cdb_valid = 1'b0;
`ifndef RS_WAKEUP_BYPASS_EN
        #1;
        check("t2_valid", 64'(issue_valid), 64'd1);
        check("t2_a", 64'(issue_a), 64'h1234);
`endif
        cycle();

        // Fill with waiting entries, wake tag 2's source first, then tag 0's.
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(6'(i), 4'(i), 1'b0, 4'(8 + i), 32'd0, 1'b1, 4'd0, 32'(i));
            cycle();
        end
        disp_valid = 1'b0;
        #1;
        check("t3_full_ready", 64'(disp_ready), 64'd0);
        check("t3_full_occ", 64'(occupancy), 64'd4);
        cdb_valid = 1'b1; cdb_tag = 4'd10; cdb_data = 32'h100;
        cycle();
        cdb_tag = 4'd8; cdb_data = 32'h200;
        cycle();
        cdb_valid = 1'b0;
        #1;
        check("t3_oldest_tag", 64'(issue_rob_tag), 64'd0);
        check("t3_oldest_a", 64'(issue_a), 64'h200);
        issue_ready = 1'b1;
        cycle();
        #1;
        check("t3_next_tag", 64'(issue_rob_tag), 64'd2);
        check("t3_next_a", 64'(issue_a), 64'h100);
        cycle();
        flush = 1'b1;
        issue_ready = 1'b0;
        cycle();
        flush = 1'b0;

        // Full station: issue frees a slot but dispatch waits a cycle; order preserved.
        for (int i = 0; i < 4; i++) begin
            disp(6'h10, 4'(4 + i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'd1);
            cycle();
        end
        disp(6'h11, 4'd8, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 32'd1);
        issue_ready = 1'b1;
        #1;
        check("t4_full_ready", 64'(disp_ready), 64'd0);
        check("t4_issue_tag", 64'(issue_rob_tag), 64'd4);
        cycle();
        issue_ready = 1'b0;
        #1;
        check("t4_ready_again", 64'(disp_ready), 64'd1);
        cycle();
        disp_valid = 1'b0;
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_order", 64'(issue_rob_tag), 64'(5 + k));
            cycle();
        end

        // Dispatch-time capture of a same-cycle broadcast.
        issue_ready = 1'b0;
        disp(6'h05, 4'd12, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd3);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'hAA;
        cycle();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        #1;
        check("t5_valid", 64'(issue_valid), 64'd1);
        check("t5_a", 64'(issue_a), 64'hAA);
        issue_ready = 1'b1;
        cycle();

        // Flush overrides a simultaneous dispatch and issue handshake.
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(6'h07, 4'(i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'd9);
            cycle();
        end
        flush = 1'b1;
        disp(6'h08, 4'd13, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
        issue_ready = 1'b1;
        #1;
        check("t6_flush_valid", 64'(issue_valid), 64'd0);
        cycle();
        flush = 1'b0;
        disp_valid = 1'b0;
        #1;
        check("t6_flush_occ", 64'(occupancy), 64'd0);
        check("t6_flush_nothing", 64'(issue_valid), 64'd0);
        cycle();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            disp($urandom_range(0, 99) < 60 ? 6'($urandom) : 6'd0, 4'($urandom),
                 1'($urandom), 4'($urandom), $urandom,
                 1'($urandom), 4'($urandom), $urandom);
            disp_valid  = $urandom_range(0, 99) < 60;
            cdb_valid   = $urandom_range(0, 99) < 50;
            cdb_tag     = 4'($urandom);
            cdb_data    = $urandom;
            issue_ready = $urandom_range(0, 99) < 70;
            flush       = $urandom_range(0, 99) < 2;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
